// File: rtl/uart_bridge_pkg.sv
// Shared UART bridge definitions: scheduler state encoding and
// default framing bytes used by both TX scheduler and RX parser.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAG   = 2'd1,
        DATA  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [7:0] TAG0_DEF  = 8'hA0;
    localparam logic [7:0] TAG1_DEF  = 8'hA1;
    localparam logic [7:0] ABORT_DEF = 8'hEE;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the previous winner loses a tie.
// Purely combinational, grant history is held by the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_id
);

    assign gnt_valid = en & (|req);
    assign gnt_id    = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares the UART TX FIFO write port between two message sources,
// one tagged message at a time, with stall timeout and abort byte.
module uart_tx_scheduler
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0] TAG0       = TAG0_DEF,
    parameter logic [7:0] TAG1       = TAG1_DEF,
    parameter logic [7:0] ABORT_BYTE = ABORT_DEF,
    parameter int         TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    output logic       s0_abort,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       s1_abort,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_din,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 2);

    state_t        state, state_nx;
    logic          gid, gid_nx;
    logic          lg, lg_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic       gnt_valid, gnt_id;
    logic       g_valid, g_last;
    logic [7:0] g_data;
    logic       wr, rdy, abrt;
    logic [7:0] din;

    rr_arb2 u_arb (
        .req        ({s1_valid, s0_valid}),
        .last_grant (lg),
        .en         (state == IDLE),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign g_valid = gid ? s1_valid : s0_valid;
    assign g_data  = gid ? s1_data  : s0_data;
    assign g_last  = gid ? s1_last  : s0_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gid   <= 1'b0;
            lg    <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            gid   <= gid_nx;
            lg    <= lg_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        gid_nx   = gid;
        lg_nx    = lg;
        cnt_nx   = '0;
        wr       = 1'b0;
        din      = 8'h00;
        rdy      = 1'b0;
        abrt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    gid_nx   = gnt_id;
                    state_nx = TAG;
                end
            end
            TAG: begin
                if (!fifo_full) begin
                    wr       = 1'b1;
                    din      = gid ? TAG1 : TAG0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                rdy    = ~fifo_full;
                cnt_nx = cnt;
                // a stalled-by-full source is not idle, so only !valid counts
                if (g_valid) begin
                    if (!fifo_full) begin
                        wr     = 1'b1;
                        din    = g_data;
                        cnt_nx = '0;
                        if (g_last) begin
                            lg_nx    = gid;
                            state_nx = IDLE;
                        end
                    end
                end else if (cnt == CNT_LIM) begin
                    cnt_nx   = '0;
                    state_nx = ABORT;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ABORT: begin
                if (!fifo_full) begin
                    wr       = 1'b1;
                    din      = ABORT_BYTE;
                    abrt     = 1'b1;
                    lg_nx    = gid;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign s0_ready   = rdy & ~gid;
    assign s1_ready   = rdy & gid;
    assign s0_abort   = abrt & ~gid;
    assign s1_abort   = abrt & gid;
    assign fifo_wr_en = wr;
    assign fifo_din   = din;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a short timeout;
// records every FIFO write and compares against hand-built streams.
module tb_uart_tx_scheduler;

    logic       clk;
    logic       rst_n;
    logic       s0_valid, s0_last, s0_ready, s0_abort;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready, s1_abort;
    logic [7:0] s1_data;
    logic       fifo_full, fifo_wr_en, busy;
    logic [7:0] fifo_din;

    uart_tx_scheduler #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_valid   (s0_valid),
        .s0_data    (s0_data),
        .s0_last    (s0_last),
        .s0_ready   (s0_ready),
        .s0_abort   (s0_abort),
        .s1_valid   (s1_valid),
        .s1_data    (s1_data),
        .s1_last    (s1_last),
        .s1_ready   (s1_ready),
        .s1_abort   (s1_abort),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] wq[$];
    logic [7:0] eq[$];
    int         wc[$];
    logic       bz[$];
    int cn, ab0, ab1, ovl, vio, rc0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive();
        s0_valid = q0.size() > 0;
        s0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        s0_last  = (q0.size() > 0) ? q0[0][8] : 1'b0;
        s1_valid = q1.size() > 0;
        s1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        s1_last  = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic cyc();
        logic a0, a1;
        @(negedge clk);
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            wc.push_back(cn);
        end
        if (fifo_wr_en && fifo_full) vio++;
        if (s0_ready && s1_ready) ovl++;
        if (s0_abort) ab0++;
        if (s1_abort) ab1++;
        if (s0_ready) rc0++;
        bz.push_back(busy);
        a0 = s0_valid & s0_ready;
        a1 = s1_valid & s1_ready;
        cn++;
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clr();
        wq.delete();
        wc.delete();
        bz.delete();
        cn = 0; ab0 = 0; ab1 = 0; ovl = 0; rc0 = 0;
    endtask

    task automatic chk_q(input string tag);
        chk({tag, ".len"}, wq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            chk($sformatf("%s[%0d]", tag, i),
                (i < wq.size()) ? {24'h0, wq[i]} : 32'hDEAD, eq[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_full = 1'b0;
        q0.delete();
        q1.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic bz_at(input int k);
        return (k >= 0 && k < bz.size()) ? bz[k] : 1'bx;
    endfunction

    function automatic int wc_at(input int k);
        return (k < wc.size()) ? wc[k] : -100;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vio = 0;
        clr();
        do_reset();
        chk("rst.busy", busy, 0);
        chk("rst.wr_en", fifo_wr_en, 0);
        chk("rst.din", fifo_din, 0);
        chk("rst.ready", {s1_ready, s0_ready}, 0);
        chk("rst.abort", {s1_abort, s0_abort}, 0);

        // 1: basic three-byte message
        clr();
        q0 = {9'h011, 9'h022, 9'h133};
        drive();
        run(10);
        eq = {8'hA0, 8'h11, 8'h22, 8'h33};
        chk_q("t1");
        chk("t1.tag_cycle", wc_at(0), 1);
        chk("t1.span", wc_at(3) - wc_at(0), 3);
        chk("t1.busy_last", bz_at(wc_at(3)), 1);
        chk("t1.busy_after", bz_at(wc_at(3) + 1), 0);

        // 2: simultaneous requests, round-robin, no interleave
        do_reset();
        clr();
        q0 = {9'h001, 9'h102, 9'h104};
        q1 = {9'h103};
        drive();
        run(20);
        eq = {8'hA0, 8'h01, 8'h02, 8'hA1, 8'h03, 8'hA0, 8'h04};
        chk_q("t2");
        chk("t2.overlap", ovl, 0);

        // 3: backpressure mid-message is not a stall
        clr();
        q0 = {9'h010, 9'h020, 9'h030, 9'h140};
        drive();
        run(3);
        chk("t3.pre_len", wq.size(), 2);
        fifo_full = 1'b1;
        rc0 = 0;
        run(10);
        chk("t3.full_writes", wq.size(), 2);
        chk("t3.full_ready", rc0, 0);
        chk("t3.full_busy", busy, 1);
        fifo_full = 1'b0;
        run(10);
        eq = {8'hA0, 8'h10, 8'h20, 8'h30, 8'h40};
        chk_q("t3");
        chk("t3.aborts", ab0 + ab1, 0);

        // 4: stall timeout on src1, then pending src0 served
        clr();
        q0 = {9'h166};
        q1 = {9'h05A};
        drive();
        run(20);
        eq = {8'hA1, 8'h5A, 8'hEE, 8'hA0, 8'h66};
        chk_q("t4");
        chk("t4.stall_span", wc_at(2) - wc_at(1), 8);
        chk("t4.s1_abort", ab1, 1);
        chk("t4.s0_abort", ab0, 0);

        // 5: single-byte message
        clr();
        q1 = {9'h17F};
        drive();
        run(8);
        eq = {8'hA1, 8'h7F};
        chk_q("t5");

        // 6: asynchronous reset mid-message
        clr();
        q0 = {9'h001, 9'h002, 9'h103};
        drive();
        run(3);
        #2;
        chk("t6.pre_wr", fifo_wr_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t6.busy", busy, 0);
        chk("t6.wr_en", fifo_wr_en, 0);
        chk("t6.din", fifo_din, 0);
        chk("t6.ready", s0_ready, 0);
        q0.delete();
        drive();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6.idle", busy, 0);
        clr();
        q0 = {9'h155};
        drive();
        run(8);
        eq = {8'hA0, 8'h55};
        chk_q("t6");

        chk("full_writes", vio, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
